// File: rtl/predecode_pkg.sv
// Shared opcode constants and branch classification for the fetch-group pre-decoder.
// Covers the LoongArch branch encodings that the pre-decoder recognises.
package predecode_pkg;

    localparam logic [5:0] OP_JIRL = 6'b010011;
    localparam logic [5:0] OP_B    = 6'b010100;
    localparam logic [5:0] OP_BL   = 6'b010101;
    localparam logic [5:0] OP_BEQ  = 6'b010110;
    localparam logic [5:0] OP_BNE  = 6'b010111;
    localparam logic [5:0] OP_BLT  = 6'b011000;
    localparam logic [5:0] OP_BGE  = 6'b011001;
    localparam logic [5:0] OP_BLTU = 6'b011010;
    localparam logic [5:0] OP_BGEU = 6'b011011;

    typedef enum logic [2:0] {
        BK_NONE,
        BK_DIRECT,
        BK_COND,
        BK_CALL,
        BK_RET,
        BK_IND
    } br_kind_e;

    // b and bl both classify as BK_DIRECT; only a jirl with rd==1 is BK_CALL.
    function automatic br_kind_e classify(input logic [31:0] inst);
        br_kind_e kind;
        kind = BK_NONE;
        case (inst[31:26])
            OP_B, OP_BL: kind = BK_DIRECT;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: kind = BK_COND;
            OP_JIRL: begin
                if (inst[4:0] == 5'd0 && inst[9:5] == 5'd1 && inst[25:10] == 16'd0)
                    kind = BK_RET;
                else if (inst[4:0] == 5'd1)
                    kind = BK_CALL;
                else
                    kind = BK_IND;
            end
            default: kind = BK_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return address stack: a push when full overwrites the oldest entry,
// and a pop on an empty stack is ignored.
module ras_stack #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        nonempty
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   entries [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW:0]   count;
    logic [PW-1:0] top_idx;

    assign top_idx  = ptr - PW'(1);
    assign top      = entries[top_idx];
    assign nonempty = (count != '0);

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the storage array sits inside the async-reset block because the
        // entries must read back as zero after reset, not as leftover data.
        if (!resetn) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (push) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values of its sources.
            entries[ptr] <= push_data;
            ptr          <= ptr + PW'(1);
            if (count != (PW+1)'(DEPTH)) count <= count + 1'b1;
        end else if (pop && nonempty) begin
            ptr   <= ptr - PW'(1);
            count <= count - 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (!resetn) !(push && pop));

endmodule

// File: rtl/predecode_ras.sv
// Fetch-group pre-decoder: classifies each lane, picks the first redirecting lane,
// truncates the group behind it, predicts returns from the RAS, and registers the result.
module predecode_ras
    import predecode_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int RAS_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_pc,
    input  logic [32*FETCH_WIDTH-1:0]   in_inst,
    input  logic [FETCH_WIDTH-1:0]      in_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_pc,
    output logic [32*FETCH_WIDTH-1:0]   out_inst,
    output logic [FETCH_WIDTH-1:0]      out_mask,
    output logic                        out_redirect,
    output logic [31:0]                 out_target,
    output logic [((FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1)-1:0] out_stop_lane,
    output logic                        out_is_ret
);

    localparam int SLW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    br_kind_e                lane_kind [FETCH_WIDTH];
    logic [31:0]             lane_pc   [FETCH_WIDTH];
    logic [31:0]             lane_tgt  [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0]  lane_stop;
    logic [FETCH_WIDTH-1:0]  lane_push;

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
        logic [31:0] inst;
        logic [31:0] off26;
        logic [31:0] off16;

        assign inst         = in_inst[32*i +: 32];
        assign lane_kind[i] = classify(inst);
        assign lane_pc[i]   = in_pc + 32'(4 * i);
        // b/bl split the 26-bit offset: low 16 bits in [25:10], high 10 bits in [9:0].
        assign off26        = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
        assign off16        = {{14{inst[25]}}, inst[25:10], 2'b00};
        assign lane_tgt[i]  = lane_pc[i] + ((lane_kind[i] == BK_DIRECT) ? off26 : off16);
        assign lane_stop[i] = in_mask[i] &&
                              ((lane_kind[i] inside {BK_DIRECT, BK_CALL, BK_RET, BK_IND}) ||
                               (lane_kind[i] == BK_COND && inst[25]));
        assign lane_push[i] = (lane_kind[i] == BK_CALL) ||
                              (lane_kind[i] == BK_DIRECT && inst[31:26] == OP_BL);
    end

    logic                   stop_found;
    logic [SLW-1:0]         stop_lane;
    br_kind_e               sel_kind;
    logic [31:0]            sel_tgt;
    logic [31:0]            sel_pc;
    logic                   sel_push;
    logic [FETCH_WIDTH-1:0] kept_mask;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        stop_found = 1'b0;
        stop_lane  = '0;
        sel_kind   = BK_NONE;
        sel_tgt    = '0;
        sel_pc     = '0;
        sel_push   = 1'b0;
        kept_mask  = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            kept_mask[i] = in_mask[i] & ~stop_found;
            if (lane_stop[i] && !stop_found) begin
                stop_found = 1'b1;
                stop_lane  = SLW'(i);
                sel_kind   = lane_kind[i];
                sel_tgt    = lane_tgt[i];
                sel_pc     = lane_pc[i];
                sel_push   = lane_push[i];
            end
        end
    end

    logic        accept;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_top;
    logic        ras_nonempty;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign ras_push = accept && stop_found && sel_push;
    assign ras_pop  = accept && stop_found && (sel_kind == BK_RET);

    ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .resetn    (resetn),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (sel_pc + 32'd4),
        .top       (ras_top),
        .nonempty  (ras_nonempty)
    );

    logic        redirect;
    logic [31:0] target;
    logic        is_ret;

    always_comb begin
        redirect = 1'b0;
        target   = '0;
        is_ret   = 1'b0;
        case (sel_kind)
            BK_DIRECT, BK_COND: begin
                redirect = 1'b1;
                target   = sel_tgt;
            end
            BK_RET: begin
                if (ras_nonempty) begin
                    redirect = 1'b1;
                    target   = ras_top;
                    is_ret   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_inst      <= '0;
            out_mask      <= '0;
            out_redirect  <= 1'b0;
            out_target    <= '0;
            out_stop_lane <= '0;
            out_is_ret    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_inst      <= in_inst;
            out_mask      <= kept_mask;
            out_redirect  <= redirect;
            out_target    <= target;
            out_stop_lane <= stop_lane;
            out_is_ret    <= is_ret;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_predecode_ras.sv
// Scoreboard bench for predecode_ras (FETCH_WIDTH=2, RAS_DEPTH=8): directed scenarios
// plus randomized groups checked against a queue-based reference model.
module tb_predecode_ras;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_ready;
    logic [31:0] in_pc, out_pc, out_target;
    logic [63:0] in_inst, out_inst;
    logic [1:0]  in_mask, out_mask;
    logic        out_valid, out_redirect, out_is_ret;
    logic [0:0]  out_stop_lane;

    always #5 clk = ~clk;

    predecode_ras #(.FETCH_WIDTH(2), .RAS_DEPTH(8)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_mask(out_mask), .out_redirect(out_redirect),
        .out_target(out_target), .out_stop_lane(out_stop_lane), .out_is_ret(out_is_ret)
    );

    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
        logic        redirect;
        logic [31:0] target;
        logic        stop;
        logic        is_ret;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_ras[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [31:0] NOP = 32'h0340_0000;
    localparam logic [31:0] ADD = 32'h0010_04a5;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [5:0] op, input int off);
        logic [25:0] i26;
        i26 = 26'(off / 4);
        return {op, i26[15:0], i26[25:16]};
    endfunction

    function automatic logic [31:0] enc_br(input logic [5:0] op, input int off,
                                           input logic [4:0] rj, input logic [4:0] rd);
        logic [15:0] i16;
        i16 = 16'(off / 4);
        return {op, i16, rj, rd};
    endfunction

    // Reference model: walk the lanes in order, stop at the first control transfer.
    function automatic exp_t model(input logic [31:0] pc, input logic [63:0] inst,
                                   input logic [1:0] mask);
        exp_t        e;
        logic [31:0] w, lpc;
        logic [5:0]  op;
        bit          hit;
        e.pc = pc; e.inst = inst; e.mask = mask;
        e.redirect = 0; e.target = 0; e.stop = 0; e.is_ret = 0;
        for (int i = 0; i < 2; i++) begin
            if (!mask[i]) continue;
            w   = inst[32*i +: 32];
            lpc = pc + 32'(4 * i);
            op  = w[31:26];
            hit = 0;
            if (op == 6'h14 || op == 6'h15) begin
                hit = 1;
                e.redirect = 1;
                e.target = lpc + 32'(int'($signed({w[9:0], w[25:10]})) * 4);
                if (op == 6'h15) begin
                    model_ras.push_back(lpc + 4);
                    if (model_ras.size() > 8) void'(model_ras.pop_front());
                end
            end else if (op >= 6'h16 && op <= 6'h1b) begin
                if (w[25]) begin
                    hit = 1;
                    e.redirect = 1;
                    e.target = lpc + 32'(int'($signed(w[25:10])) * 4);
                end
            end else if (op == 6'h13) begin
                hit = 1;
                if (w[4:0] == 0 && w[9:5] == 1 && w[25:10] == 0) begin
                    if (model_ras.size() > 0) begin
                        e.redirect = 1;
                        e.is_ret = 1;
                        e.target = model_ras.pop_back();
                    end
                end else if (w[4:0] == 1) begin
                    model_ras.push_back(lpc + 4);
                    if (model_ras.size() > 8) void'(model_ras.pop_front());
                end
            end
            if (hit) begin
                e.stop = i[0];
                if (i == 0) e.mask[1] = 1'b0;
                break;
            end
        end
        return e;
    endfunction

    task automatic send(input logic [31:0] pc, input logic [63:0] inst, input logic [1:0] mask);
        in_pc = pc; in_inst = inst; in_mask = mask; in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready && !flush && resetn) begin
                sb.push_back(model(pc, inst, mask));
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        int off;
        off = (int'($urandom_range(0, 2000)) - 1000) * 4;
        case ($urandom_range(0, 6))
            0: return NOP;
            1: return enc_b(6'h14, off);
            2: return enc_b(6'h15, off);
            3: return enc_br(6'(6'h16 + $urandom_range(0, 5)), off, 5'd4, 5'd5);
            4: return enc_br(6'h13, 0, 5'd1, 5'd0);
            5: return enc_br(6'h13, off, 5'(ADD), 5'd1);
            default: return enc_br(6'h13, off, 5'd7, 5'(2 + $urandom_range(0, 29)));
        endcase
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (resetn) begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pc", out_pc, mon_e.pc);
                    check("inst", out_inst, mon_e.inst);
                    check("mask", out_mask, mon_e.mask);
                    check("redirect", out_redirect, mon_e.redirect);
                    check("target", out_target, mon_e.target);
                    check("stop_lane", out_stop_lane, mon_e.stop);
                    check("is_ret", out_is_ret, mon_e.is_ret);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    logic [31:0] hold_pc, hold_tgt;
    logic [63:0] hold_inst;
    bit          rand_done;

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0; in_mask = '0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_inst", out_inst, 0);
        check("rst_fields", {out_mask, out_redirect, out_target, out_stop_lane, out_is_ret}, 0);
        @(posedge clk); #1;
        resetn = 1'b1; out_ready = 1'b1;

        // bl +0x100 in lane 0 truncates the add in lane 1.
        send(32'h1c00_0000, {ADD, enc_b(6'h15, 32'h100)}, 2'b11);
        check("bl_mask", out_mask, 2'b01);
        check("bl_redirect", out_redirect, 1);
        check("bl_target", out_target, 32'h1c00_0100);
        check("bl_stop", out_stop_lane, 0);

        send(32'h1c00_0100, {enc_br(6'h13, 0, 5'd1, 5'd0), NOP}, 2'b11);
        check("ret_mask", out_mask, 2'b11);
        check("ret_stop", out_stop_lane, 1);
        check("ret_is_ret", out_is_ret, 1);
        check("ret_target", out_target, 32'h1c00_0004);

        send(32'h0000_1000, {enc_br(6'h17, -16, 5'd1, 5'd2), enc_br(6'h16, 8, 5'd1, 5'd2)}, 2'b11);
        check("cond_redirect", out_redirect, 1);
        check("cond_target", out_target, 32'h0000_0ff4);
        check("cond_mask", out_mask, 2'b11);
        check("cond_stop", out_stop_lane, 1);

        // Nine calls into an 8-deep stack, then nine returns.
        for (int k = 0; k < 9; k++)
            send(32'h2000_0000 + 32'(k * 256), {NOP, enc_b(6'h15, 64)}, 2'b01);
        for (int k = 0; k < 9; k++) begin
            send(32'h3000_0000, {NOP, enc_br(6'h13, 0, 5'd1, 5'd0)}, 2'b01);
            if (k < 8) check("ovf_target", out_target, 32'h2000_0004 + 32'((8 - k) * 256));
            else       check("ovf_empty_redirect", out_redirect, 0);
        end

        // Backpressure: the 9th return group holds while a new group waits.
        out_ready = 1'b0;
        in_pc = 32'h4000; in_inst = {NOP, NOP}; in_mask = 2'b11; in_valid = 1'b1;
        hold_pc = out_pc; hold_inst = out_inst; hold_tgt = out_target;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_pc", out_pc, 32'h3000_0000);
            check("bp_stable", {out_inst, out_target}, {hold_inst, hold_tgt});
        end
        out_ready = 1'b1;
        send(32'h4000, {NOP, NOP}, 2'b11);

        // A flushed bl must not touch the RAS.
        send(32'h5000, {NOP, enc_b(6'h15, 64)}, 2'b01);
        in_pc = 32'h6000; in_inst = {NOP, enc_b(6'h15, 64)}; in_mask = 2'b01;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        send(32'h7000, {NOP, enc_br(6'h13, 0, 5'd1, 5'd0)}, 2'b01);
        check("flush_ras_target", out_target, 32'h5004);

        rand_done = 0;
        fork
            begin
                for (int n = 0; n < 300; n++)
                    send($urandom() & 32'hffff_fffc, {rand_inst(), rand_inst()},
                         2'($urandom_range(0, 3)));
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 0);

        // Reset with a call group held at the output.
        out_ready = 1'b0;
        send(32'h8000, {NOP, enc_b(6'h15, 64)}, 2'b01);
        resetn = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_all", {out_pc, out_inst, out_mask, out_redirect, out_target,
                             out_stop_lane, out_is_ret} == '0, 1);
        @(posedge clk); #1;
        sb.delete(); model_ras.delete();
        resetn = 1'b1; out_ready = 1'b1;
        send(32'h9000, {NOP, enc_br(6'h13, 0, 5'd1, 5'd0)}, 2'b01);
        check("midrst_ret_redirect", out_redirect, 0);
        check("midrst_ret_is_ret", out_is_ret, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
